// File: rtl/game_timer_bcd_if.sv
// game_timer_bcd_if
//   Groups the game-timer control inputs and BCD/status outputs.
//   master : the game controller side (drives activity/pause/win/restart/preset)
//   slave  : the timer itself (drives digits/running/expired/tick)
//   activity : one-cycle user-action pulse, starts the timer from idle
//   pause    : level, suspends timing while running
//   win      : level, freezes the count until restart/reset
//   restart  : one-cycle pulse, returns to idle and reloads the count
//   preset   : BCD start value for count-down builds
//   digits   : registered BCD count, digit 0 least significant
//   running  : timer is counting
//   expired  : count reached its end value
//   tick     : one-cycle pulse when digits shows a newly counted second
interface game_timer_bcd_if #(
    parameter int DIGITS = 2
) ();
    logic                  activity;
    logic                  pause;
    logic                  win;
    logic                  restart;
    logic [4*DIGITS-1:0]   preset;
    logic [4*DIGITS-1:0]   digits;
    logic                  running;
    logic                  expired;
    logic                  tick;

    modport master (
        output activity, pause, win, restart, preset,
        input  digits, running, expired, tick
    );

    modport slave (
        input  activity, pause, win, restart, preset,
        output digits, running, expired, tick
    );
endinterface

// File: rtl/game_timer_bcd.sv
// game_timer_bcd
//   Parametrised BCD game timer: counts seconds up from zero or down from a
//   BCD preset, with pause, restart, win freeze and expiry detection.
//   Ports:
//     CLK  : system clock
//     RST  : synchronous active-high reset
//     bus  : game_timer_bcd_if.slave (controls in, BCD count and status out)
//   Parameters:
//     DIGITS     : number of BCD digits (1..6)
//     TICK_DIV   : clock cycles per counted second (>= 2)
//     COUNT_DOWN : 0 = count up from zero, 1 = count down from preset
module game_timer_bcd #(
    parameter int DIGITS     = 2,
    parameter int TICK_DIV   = 50000000,
    parameter int COUNT_DOWN = 0
) (
    input  logic              CLK,
    input  logic              RST,
    game_timer_bcd_if.slave   bus
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_DONE,
        S_EXPIRED
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [W-1:0]    digits_q, digits_d;
    logic            tick_q, tick_d;
    logic [W-1:0]    load_v;
    logic [W:0]      inc_r;
    logic [W-1:0]    dec_r;

    // Count-up builds always start from zero; count-down builds clamp any
    // non-decimal preset nibble to 9.
    function automatic logic [W-1:0] load_value(input logic [W-1:0] p);
        logic [W-1:0] v;
        v = '0;
        if (COUNT_DOWN != 0) begin
            for (int i = 0; i < DIGITS; i++) begin
                v[4*i +: 4] = (p[4*i +: 4] > 4'd9) ? 4'd9 : p[4*i +: 4];
            end
        end
        return v;
    endfunction

    // BCD increment; MSB of the result is the carry out of the top digit,
    // which signals an all-9s input.
    function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    // BCD decrement with ripple borrow. Never called on zero in practice,
    // since reaching zero moves the timer to EXPIRED.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        digits_d = digits_q;
        tick_d   = 1'b0;
        load_v   = load_value(bus.preset);
        inc_r    = bcd_inc(digits_q);
        dec_r    = bcd_dec(digits_q);

        if (bus.restart) begin
            state_d  = S_IDLE;
            presc_d  = '0;
            digits_d = load_v;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // Preset is tracked live while idle.
                    digits_d = load_v;
                    presc_d  = '0;
                    if (bus.win) begin
                        state_d = S_DONE;
                    end else if (bus.activity) begin
                        state_d = ((COUNT_DOWN != 0) && (load_v == '0)) ? S_EXPIRED : S_RUN;
                    end
                end
                S_RUN: begin
                    // win and pause both suppress a would-be step this cycle.
                    if (bus.win) begin
                        state_d = S_DONE;
                    end else if (bus.pause) begin
                        state_d = S_PAUSED;
                    end else if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        if (COUNT_DOWN != 0) begin
                            digits_d = dec_r;
                            if (dec_r == '0) begin
                                state_d = S_EXPIRED;
                            end
                        end else if (inc_r[W]) begin
                            // All 9s: hold rather than wrap to zero.
                            state_d = S_EXPIRED;
                        end else begin
                            digits_d = inc_r[W-1:0];
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                S_PAUSED: begin
                    // Prescaler holds so a partial second survives the pause.
                    if (bus.win) begin
                        state_d = S_DONE;
                    end else if (!bus.pause) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    // DONE / EXPIRED are terminal until restart or reset.
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            digits_q <= load_value(bus.preset);
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            digits_q <= digits_d;
            tick_q   <= tick_d;
        end
    end

    assign bus.digits  = digits_q;
    assign bus.running = (state_q == S_RUN);
    assign bus.expired = (state_q == S_EXPIRED);
    assign bus.tick    = tick_q;
endmodule

// File: tb/tb_game_timer_bcd.sv
module tb_game_timer_bcd;
    logic       clk = 1'b0;
    logic       rst;
    logic       activity, pause, win, restart;
    logic [7:0] preset;

    int total = 0;
    int bad   = 0;

    // Reference model: integer count value and a coarse mode per timer.
    // Index 0 = count-up timer, index 1 = count-down timer.
    // mode: 0 idle, 1 running, 2 paused, 3 done, 4 expired
    int m_val[2];
    int m_mode[2];
    int m_sub[2];
    int m_tick[2];

    game_timer_bcd_if #(.DIGITS(2)) ifu ();
    game_timer_bcd_if #(.DIGITS(2)) ifd ();

    assign ifu.activity = activity;
    assign ifu.pause    = pause;
    assign ifu.win      = win;
    assign ifu.restart  = restart;
    assign ifu.preset   = preset;
    assign ifd.activity = activity;
    assign ifd.pause    = pause;
    assign ifd.win      = win;
    assign ifd.restart  = restart;
    assign ifd.preset   = preset;

    game_timer_bcd #(.DIGITS(2), .TICK_DIV(4), .COUNT_DOWN(0)) dut_up (
        .CLK (clk),
        .RST (rst),
        .bus (ifu)
    );

    game_timer_bcd #(.DIGITS(2), .TICK_DIV(4), .COUNT_DOWN(1)) dut_dn (
        .CLK (clk),
        .RST (rst),
        .bus (ifd)
    );

    always #5 clk = ~clk;

    function automatic int load_val(input int idx);
        int hi, lo;
        if (idx == 0) return 0;
        hi = int'(preset[7:4]);
        lo = int'(preset[3:0]);
        if (hi > 9) hi = 9;
        if (lo > 9) lo = 9;
        return hi * 10 + lo;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_upd(input int idx);
        m_tick[idx] = 0;
        if (rst || restart) begin
            m_mode[idx] = 0;
            m_val[idx]  = load_val(idx);
            m_sub[idx]  = 0;
        end else begin
            case (m_mode[idx])
                0: begin
                    m_val[idx] = load_val(idx);
                    m_sub[idx] = 0;
                    if (win) m_mode[idx] = 3;
                    else if (activity) m_mode[idx] = (idx == 1 && m_val[idx] == 0) ? 4 : 1;
                end
                1: begin
                    if (win) m_mode[idx] = 3;
                    else if (pause) m_mode[idx] = 2;
                    else begin
                        m_sub[idx]++;
                        if (m_sub[idx] == 4) begin
                            m_sub[idx]  = 0;
                            m_tick[idx] = 1;
                            if (idx == 0) begin
                                if (m_val[idx] == 99) m_mode[idx] = 4;
                                else m_val[idx]++;
                            end else begin
                                m_val[idx]--;
                                if (m_val[idx] == 0) m_mode[idx] = 4;
                            end
                        end
                    end
                end
                2: begin
                    if (win) m_mode[idx] = 3;
                    else if (!pause) m_mode[idx] = 1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        model_upd(0);
        model_upd(1);
        #1;
        chk("m_up_digits",  ifu.digits,  to_bcd(m_val[0]));
        chk("m_up_running", ifu.running, (m_mode[0] == 1));
        chk("m_up_expired", ifu.expired, (m_mode[0] == 4));
        chk("m_up_tick",    ifu.tick,    m_tick[0]);
        chk("m_dn_digits",  ifd.digits,  to_bcd(m_val[1]));
        chk("m_dn_running", ifd.running, (m_mode[1] == 1));
        chk("m_dn_expired", ifd.expired, (m_mode[1] == 4));
        chk("m_dn_tick",    ifd.tick,    m_tick[1]);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    initial begin
        rst = 1'b1; activity = 1'b0; pause = 1'b0; win = 1'b0; restart = 1'b0;
        preset = 8'h12;
        for (int i = 0; i < 2; i++) begin
            m_val[i] = 0; m_mode[i] = 0; m_sub[i] = 0; m_tick[i] = 0;
        end

        // Reset values
        cycles(2);
        chk("rst_up_digits",  ifu.digits,  8'h00);
        chk("rst_dn_digits",  ifd.digits,  8'h12);
        chk("rst_up_running", ifu.running, 1'b0);
        chk("rst_dn_expired", ifd.expired, 1'b0);
        chk("rst_up_tick",    ifu.tick,    1'b0);
        rst = 1'b0;

        // Start and first tick
        activity = 1'b1; step_cycle(); activity = 1'b0;
        chk("start_running", ifu.running, 1'b1);
        cycles(3);
        chk("pre_first_tick", ifu.tick, 1'b0);
        step_cycle();
        chk("first_tick",     ifu.tick,   1'b1);
        chk("first_up_digit", ifu.digits, 8'h01);
        chk("first_dn_digit", ifd.digits, 8'h11);
        cycles(36);
        chk("up_after_40", ifu.digits, 8'h10);
        chk("dn_after_40", ifd.digits, 8'h02);
        cycles(8);
        chk("dn_zero_digits",  ifd.digits,  8'h00);
        chk("dn_zero_expired", ifd.expired, 1'b1);
        chk("dn_zero_running", ifd.running, 1'b0);

        // Count-up saturation at 99 (bounded wait)
        for (int i = 0; i < 400 && ifu.expired !== 1'b1; i++) step_cycle();
        chk("wrap_expired", ifu.expired, 1'b1);
        chk("wrap_digits",  ifu.digits,  8'h99);
        chk("wrap_running", ifu.running, 1'b0);
        chk("wrap_tick",    ifu.tick,    1'b1);
        cycles(20);
        chk("wrap_hold_digits", ifu.digits, 8'h99);
        chk("wrap_hold_tick",   ifu.tick,   1'b0);

        // Restart reloads
        restart = 1'b1; step_cycle(); restart = 1'b0;
        chk("restart_up", ifu.digits,  8'h00);
        chk("restart_dn", ifd.digits,  8'h12);
        chk("restart_ex", ifu.expired, 1'b0);

        // Pause preserves partial second
        activity = 1'b1; step_cycle(); activity = 1'b0;
        cycles(2);
        pause = 1'b1; cycles(10);
        chk("paused_digits",  ifu.digits,  8'h00);
        chk("paused_running", ifu.running, 1'b0);
        pause = 1'b0; cycles(2);
        chk("post_pause_no_tick", ifu.tick, 1'b0);
        step_cycle();
        chk("post_pause_tick",   ifu.tick,   1'b1);
        chk("post_pause_digits", ifu.digits, 8'h01);

        // Win on a would-be tick
        cycles(3);
        win = 1'b1; step_cycle(); win = 1'b0;
        chk("win_tick",    ifu.tick,    1'b0);
        chk("win_running", ifu.running, 1'b0);
        chk("win_up",      ifu.digits,  8'h01);
        chk("win_dn",      ifd.digits,  8'h11);
        activity = 1'b1; pause = 1'b1; step_cycle(); activity = 1'b0;
        cycles(8); pause = 1'b0; cycles(4);
        chk("frozen_up",      ifu.digits,  8'h01);
        chk("frozen_running", ifu.running, 1'b0);
        chk("frozen_dn",      ifd.digits,  8'h11);
        restart = 1'b1; step_cycle(); restart = 1'b0;
        chk("win_restart_up", ifu.digits, 8'h00);
        chk("win_restart_dn", ifd.digits, 8'h12);

        // Zero preset expires immediately
        preset = 8'h00; step_cycle();
        chk("live_preset", ifd.digits, 8'h00);
        activity = 1'b1; step_cycle(); activity = 1'b0;
        chk("zero_expired", ifd.expired, 1'b1);
        chk("zero_tick",    ifd.tick,    1'b0);
        chk("zero_up_run",  ifu.running, 1'b1);

        // Clamped preset and mid-count reset
        preset = 8'hA5; rst = 1'b1; step_cycle(); rst = 1'b0;
        chk("clamp_a5", ifd.digits, 8'h95);
        activity = 1'b1; step_cycle(); activity = 1'b0;
        cycles(6);
        rst = 1'b1; step_cycle(); rst = 1'b0;
        chk("midrst_up_digits",  ifu.digits,  8'h00);
        chk("midrst_up_running", ifu.running, 1'b0);
        chk("midrst_up_tick",    ifu.tick,    1'b0);
        chk("midrst_dn_digits",  ifd.digits,  8'h95);
        chk("midrst_dn_expired", ifd.expired, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            restart  = ($urandom_range(0, 39) == 0);
            win      = ($urandom_range(0, 79) == 0);
            activity = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) pause = ~pause;
            if ($urandom_range(0, 49) == 0) preset = 8'($urandom_range(0, 255));
            step_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
